// File: rtl/pueo_turfhdr_framer_if.sv
// Header-in / frame-out stream bundle for pueo_turfhdr_framer.
// The framer uses the slave view; the trigger processor and event builder side use master.
interface pueo_turfhdr_framer_if;
  logic [63:0] s_hdr_tdata;
  logic        s_hdr_tvalid;
  logic        s_hdr_tready;
  logic [31:0] m_ev_tdata;
  logic        m_ev_tvalid;
  logic        m_ev_tready;
  logic        m_ev_tlast;

  modport slave (
    input  s_hdr_tdata, s_hdr_tvalid, m_ev_tready,
    output s_hdr_tready, m_ev_tdata, m_ev_tvalid, m_ev_tlast
  );

  modport master (
    output s_hdr_tdata, s_hdr_tvalid, m_ev_tready,
    input  s_hdr_tready, m_ev_tdata, m_ev_tvalid, m_ev_tlast
  );
endinterface

// File: rtl/pueo_turfhdr_framer.sv
// TURF header framer: FIFO-buffers 64-bit headers, stamps evno/timestamp, emits 32-bit frames.
// Define PUEO_TURFHDR_CHECKSUM_EN to append a fifth XOR checksum word carrying tlast.
module pueo_turfhdr_framer #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  MAGIC = 8'hA5
) (
  input  logic                   sysclk_i,
  input  logic                   rst_n_i,
  input  logic                   runrst_i,
  pueo_turfhdr_framer_if.slave   bus,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [23:0]            evcount_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [63:0] hdr;
    logic [23:0] evno;
    logic [31:0] ts;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_W2,
    S_W3
`ifdef PUEO_TURFHDR_CHECKSUM_EN
    , S_W4
`endif
  } state_t;

  entry_t        mem_q [DEPTH];
  logic [31:0]   ts_q, ts_d;
  logic [23:0]   evcnt_q, evcnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          tready_q, tready_d;
  state_t        state_q, state_d;
  entry_t        cur_q, cur_d;
  logic [31:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;

  logic          push, pop, hs, frame_done, load_next;
  entry_t        wr_entry, head;
`ifdef PUEO_TURFHDR_CHECKSUM_EN
  logic [31:0]   csum;
`endif

  // Stamp with this cycle's values; a same-cycle runrst forces both stamps to zero.
  always_comb begin
    push          = bus.s_hdr_tvalid && tready_q;
    wr_entry.hdr  = bus.s_hdr_tdata;
    wr_entry.evno = runrst_i ? 24'd0 : evcnt_q;
    wr_entry.ts   = runrst_i ? 32'd0 : ts_q;
    ts_d          = runrst_i ? 32'd0 : ts_q + 32'd1;
    evcnt_d       = (runrst_i ? 24'd0 : evcnt_q) + 24'(push);
    head          = mem_q[rd_ptr_q];
    hs            = tvalid_q && bus.m_ev_tready;
  end

`ifdef PUEO_TURFHDR_CHECKSUM_EN
  assign csum = {MAGIC, cur_q.evno} ^ cur_q.hdr[31:0] ^ cur_q.hdr[63:32] ^ cur_q.ts;
`endif

  // Frame sequencer: each word advances only on an output handshake.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    frame_done = 1'b0;
    load_next  = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: load_next = (level_q != '0);
      S_W0: if (hs) begin
        state_d = S_W1;
        tdata_d = cur_q.hdr[31:0];
      end
      S_W1: if (hs) begin
        state_d = S_W2;
        tdata_d = cur_q.hdr[63:32];
      end
      S_W2: if (hs) begin
        state_d = S_W3;
        tdata_d = cur_q.ts;
`ifndef PUEO_TURFHDR_CHECKSUM_EN
        tlast_d = 1'b1;
`endif
      end
`ifdef PUEO_TURFHDR_CHECKSUM_EN
      S_W3: if (hs) begin
        state_d = S_W4;
        tdata_d = csum;
        tlast_d = 1'b1;
      end
      S_W4: frame_done = hs;
`else
      S_W3: frame_done = hs;
`endif
      default: state_d = S_IDLE;
    endcase

    // Closing handshake chains straight into the next entry when one is waiting.
    if (frame_done) begin
      load_next = (level_q != '0);
      if (level_q == '0) begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end

    if (load_next) begin
      pop      = 1'b1;
      cur_d    = head;
      state_d  = S_W0;
      tdata_d  = {MAGIC, head.evno};
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
    end
  end

  // tready is derived from next occupancy, so a pop only frees a slot from the next cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    tready_d = (level_d != LW'(DEPTH));
  end

  always_ff @(posedge sysclk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts_q     <= '0;
      evcnt_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
      state_q  <= S_IDLE;
      cur_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      evcnt_q  <= evcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tready_q <= tready_d;
      state_q  <= state_d;
      cur_q    <= cur_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign bus.s_hdr_tready = tready_q;
  assign bus.m_ev_tdata   = tdata_q;
  assign bus.m_ev_tvalid  = tvalid_q;
  assign bus.m_ev_tlast   = tlast_q;
  assign fifo_level_o     = level_q;
  assign evcount_o        = evcnt_q;
endmodule

// File: tb/tb_pueo_turfhdr_framer.sv
// Self-checking bench for pueo_turfhdr_framer: directed vector table, corner sequences,
// and randomized traffic scored against a queue-based frame model.
module tb_pueo_turfhdr_framer;
  localparam int unsigned DEPTH = 16;
`ifdef PUEO_TURFHDR_CHECKSUM_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic        sysclk_i = 1'b0;
  logic        rst_n_i;
  logic        runrst_i;
  logic [4:0]  fifo_level_o;
  logic [23:0] evcount_o;

  pueo_turfhdr_framer_if bus();

  pueo_turfhdr_framer #(.DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
    .sysclk_i     (sysclk_i),
    .rst_n_i      (rst_n_i),
    .runrst_i     (runrst_i),
    .bus          (bus),
    .fifo_level_o (fifo_level_o),
    .evcount_o    (evcount_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  typedef struct {
    logic [63:0] hdr;
    logic [23:0] evno;
    logic [31:0] ts;
  } exp_t;

  typedef struct {
    logic [63:0] hdr;
    int          stall;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [23:0] evno;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q[$];
  exp_t        cur;
  int          idx = 0;
  bit          have_cur = 1'b0;
  bit          b2b = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] st_data;
  logic        st_last;
  logic [23:0] m_ev = '0;
  logic [31:0] m_ts = '0;
  bit          force_on = 1'b0;
  logic [23:0] force_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame layout straight from the word definitions.
  function automatic logic [31:0] frame_word(input exp_t e, input int i);
    logic [31:0] w [5];
    w[0] = {8'hA5, e.evno};
    w[1] = e.hdr[31:0];
    w[2] = e.hdr[63:32];
    w[3] = e.ts;
    w[4] = w[0] ^ w[1] ^ w[2] ^ w[3];
    return w[i];
  endfunction

  // Mid-cycle observer: scores output words, then records this cycle's accepted header.
  task automatic mon_step();
    logic [23:0] s_ev;
    logic [31:0] s_ts;
    if (!rst_n_i) begin
      q.delete();
      idx = 0; have_cur = 1'b0; b2b = 1'b0; stalled = 1'b0;
      m_ev = '0; m_ts = '0;
      return;
    end
    if (b2b) chk("b2b_no_bubble", 64'(bus.m_ev_tvalid), 64'd1);
    b2b = 1'b0;
    if (stalled) begin
      chk("stall_tvalid", 64'(bus.m_ev_tvalid), 64'd1);
      chk("stall_tdata", 64'(bus.m_ev_tdata), 64'(st_data));
      chk("stall_tlast", 64'(bus.m_ev_tlast), 64'(st_last));
    end
    stalled = 1'b0;
    if (idx != 0) chk("midframe_tvalid", 64'(bus.m_ev_tvalid), 64'd1);
    if (bus.m_ev_tvalid) begin
      if (idx == 0 && !have_cur) begin
        if (q.size() == 0) chk("spurious_tvalid", 64'(bus.m_ev_tvalid), 64'd0);
        else begin
          cur = q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        chk("model_word", 64'(bus.m_ev_tdata), 64'(frame_word(cur, idx)));
        chk("model_tlast", 64'(bus.m_ev_tlast), 64'(idx == NW - 1));
      end
      if (bus.m_ev_tready) begin
        if (idx == NW - 1) begin
          idx = 0;
          have_cur = 1'b0;
          b2b = (q.size() > 0);
        end else idx++;
      end else begin
        stalled = 1'b1;
        st_data = bus.m_ev_tdata;
        st_last = bus.m_ev_tlast;
      end
    end
    if (force_on) m_ev = force_val;
    else chk("evcount", 64'(evcount_o), 64'(m_ev));
    s_ev = runrst_i ? 24'd0 : m_ev;
    s_ts = runrst_i ? 32'd0 : m_ts;
    if (bus.s_hdr_tvalid && bus.s_hdr_tready) begin
      q.push_back('{hdr: bus.s_hdr_tdata, evno: s_ev, ts: s_ts});
      s_ev = s_ev + 24'd1;
    end
    m_ev = s_ev;
    m_ts = runrst_i ? 32'd0 : m_ts + 32'd1;
  endtask

  task automatic tick();
    @(posedge sysclk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    runrst_i = 1'b0;
    bus.s_hdr_tvalid = 1'b0;
    bus.m_ev_tready = 1'b1;
    tick();
    tick();
    chk("rst_s_tready", 64'(bus.s_hdr_tready), 64'd0);
    chk("rst_tvalid", 64'(bus.m_ev_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus.m_ev_tlast), 64'd0);
    chk("rst_tdata", 64'(bus.m_ev_tdata), 64'd0);
    chk("rst_level", 64'(fifo_level_o), 64'd0);
    chk("rst_evcount", 64'(evcount_o), 64'd0);
    rst_n_i = 1'b1;
    cyc = 0;
    tick();
    chk("rel_s_tready", 64'(bus.s_hdr_tready), 64'd1);
  endtask

  task automatic collect(output logic [31:0] w [5], input int stall_at, input int stall_n);
    int t;
    t = 0;
    for (int k = 0; k < 5; k++) w[k] = '0;
    while (!bus.m_ev_tvalid && t < 60) begin
      tick();
      t++;
    end
    chk("frame_start", 64'(bus.m_ev_tvalid), 64'd1);
    if (!bus.m_ev_tvalid) return;
    for (int i = 0; i < NW; i++) begin
      chk("frame_tvalid", 64'(bus.m_ev_tvalid), 64'd1);
      w[i] = bus.m_ev_tdata;
      chk("frame_tlast", 64'(bus.m_ev_tlast), 64'(i == NW - 1));
      if (i == stall_at) begin
        bus.m_ev_tready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("hold_tdata", 64'(bus.m_ev_tdata), 64'(w[i]));
          chk("hold_tlast", 64'(bus.m_ev_tlast), 64'(i == NW - 1));
          chk("hold_tvalid", 64'(bus.m_ev_tvalid), 64'd1);
        end
        bus.m_ev_tready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic force_ev(input logic [23:0] v);
    force_val = v;
    force_on = 1'b1;
    force dut.evcnt_q = v;
    tick();
    release dut.evcnt_q;
    force_on = 1'b0;
    chk("preset_evcount", 64'(evcount_o), 64'(v));
  endtask

  initial begin
    vec_t        tbl [4];
    logic [31:0] fw [5];
    logic [31:0] exp_ts;
    int          sent;
    bit          acc;
    int          t;

    tbl[0] = '{hdr: 64'h0123_4567_89AB_CDEF, stall: 0, w1: 32'h89AB_CDEF, w2: 32'h0123_4567, evno: 24'd0};
    tbl[1] = '{hdr: 64'hFFFF_FFFF_0000_0000, stall: 3, w1: 32'h0000_0000, w2: 32'hFFFF_FFFF, evno: 24'd1};
    tbl[2] = '{hdr: 64'hDEAD_BEEF_CAFE_F00D, stall: 1, w1: 32'hCAFE_F00D, w2: 32'hDEAD_BEEF, evno: 24'd2};
    tbl[3] = '{hdr: 64'h0000_0000_0000_0000, stall: 0, w1: 32'h0000_0000, w2: 32'h0000_0000, evno: 24'd3};

    rst_n_i = 1'b0;
    runrst_i = 1'b0;
    bus.s_hdr_tvalid = 1'b0;
    bus.s_hdr_tdata = '0;
    bus.m_ev_tready = 1'b1;

    fork
      forever begin
        @(negedge sysclk_i);
        mon_step();
      end
    join_none

    do_reset();

    // Directed vectors: latency, word layout, timestamp, and a W2 stall.
    for (int v = 0; v < 4; v++) begin
      bus.s_hdr_tdata = tbl[v].hdr;
      bus.s_hdr_tvalid = 1'b1;
      exp_ts = 32'(cyc);
      tick();
      bus.s_hdr_tvalid = 1'b0;
      chk("lat_edge_n1", 64'(bus.m_ev_tvalid), 64'd0);
      tick();
      chk("lat_edge_n2", 64'(bus.m_ev_tvalid), 64'd1);
      collect(fw, (tbl[v].stall > 0) ? 2 : -1, tbl[v].stall);
      chk("vec_w0", 64'(fw[0]), 64'({8'hA5, tbl[v].evno}));
      chk("vec_w1", 64'(fw[1]), 64'(tbl[v].w1));
      chk("vec_w2", 64'(fw[2]), 64'(tbl[v].w2));
      chk("vec_w3", 64'(fw[3]), 64'(exp_ts));
`ifdef PUEO_TURFHDR_CHECKSUM_EN
      chk("vec_w4", 64'(fw[4]), 64'({8'hA5, tbl[v].evno} ^ tbl[v].w1 ^ tbl[v].w2 ^ exp_ts));
`endif
      chk("vec_evcount", 64'(evcount_o), 64'(tbl[v].evno + 24'd1));
    end

    // Fill with the output stalled, then drain back-to-back.
    do_reset();
    bus.m_ev_tready = 1'b0;
    sent = 0;
    for (int c = 0; c < 30 && sent < 20; c++) begin
      bus.s_hdr_tvalid = 1'b1;
      bus.s_hdr_tdata = {32'hF111_0000 + 32'(sent), 32'(sent)};
      acc = bus.s_hdr_tready;
      tick();
      if (acc) sent++;
    end
    bus.s_hdr_tvalid = 1'b0;
    chk("fill_accepted", 64'(sent), 64'd17);
    chk("fill_level", 64'(fifo_level_o), 64'(DEPTH));
    chk("fill_s_tready", 64'(bus.s_hdr_tready), 64'd0);
    chk("fill_evcount", 64'(evcount_o), 64'd17);
    bus.m_ev_tready = 1'b1;
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < NW; i++) begin
        chk("drain_tvalid", 64'(bus.m_ev_tvalid), 64'd1);
        if (i == 0) chk("drain_w0", 64'(bus.m_ev_tdata), 64'({8'hA5, 24'(f)}));
        tick();
      end
    end
    chk("drain_idle_tvalid", 64'(bus.m_ev_tvalid), 64'd0);
    chk("drain_level", 64'(fifo_level_o), 64'd0);

    // runrst in the same cycle as a header accept.
    force_ev(24'h000123);
    bus.s_hdr_tdata = 64'h1111_2222_3333_4444;
    bus.s_hdr_tvalid = 1'b1;
    runrst_i = 1'b1;
    tick();
    bus.s_hdr_tvalid = 1'b0;
    runrst_i = 1'b0;
    chk("runrst_evcount", 64'(evcount_o), 64'd1);
    collect(fw, -1, 0);
    chk("runrst_w0", 64'(fw[0]), 64'h0000_0000_A500_0000);
    chk("runrst_w3", 64'(fw[3]), 64'd0);

    // Event counter wrap.
    force_ev(24'hFFFFFF);
    bus.s_hdr_tdata = 64'hAAAA_0000_BBBB_0001;
    bus.s_hdr_tvalid = 1'b1;
    tick();
    bus.s_hdr_tdata = 64'hAAAA_0000_BBBB_0002;
    tick();
    bus.s_hdr_tvalid = 1'b0;
    chk("wrap_evcount", 64'(evcount_o), 64'd1);
    collect(fw, -1, 0);
    chk("wrap_w0_a", 64'(fw[0]), 64'h0000_0000_A5FF_FFFF);
    collect(fw, -1, 0);
    chk("wrap_w0_b", 64'(fw[0]), 64'h0000_0000_A500_0000);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.s_hdr_tvalid = ($urandom_range(0, 2) != 0);
      bus.s_hdr_tdata = {$urandom, $urandom};
      bus.m_ev_tready = ($urandom_range(0, 3) != 0);
      runrst_i = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.s_hdr_tvalid = 1'b0;
    runrst_i = 1'b0;
    bus.m_ev_tready = 1'b1;
    t = 0;
    while ((q.size() != 0 || idx != 0 || bus.m_ev_tvalid) && t < 500) begin
      tick();
      t++;
    end
    chk("rand_drained", 64'(q.size()), 64'd0);
    chk("rand_idle_tvalid", 64'(bus.m_ev_tvalid), 64'd0);

    // Asynchronous reset during W1 with another entry queued.
    bus.s_hdr_tdata = 64'h5555_6666_7777_8888;
    bus.s_hdr_tvalid = 1'b1;
    tick();
    bus.s_hdr_tvalid = 1'b0;
    t = 0;
    while (!bus.m_ev_tvalid && t < 20) begin
      tick();
      t++;
    end
    tick();
    bus.m_ev_tready = 1'b0;
    bus.s_hdr_tvalid = 1'b1;
    tick();
    bus.s_hdr_tvalid = 1'b0;
    chk("pre_abort_tvalid", 64'(bus.m_ev_tvalid), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("abort_tvalid", 64'(bus.m_ev_tvalid), 64'd0);
    chk("abort_tlast", 64'(bus.m_ev_tlast), 64'd0);
    chk("abort_level", 64'(fifo_level_o), 64'd0);
    do_reset();
    bus.s_hdr_tdata = 64'h9999_AAAA_BBBB_CCCC;
    bus.s_hdr_tvalid = 1'b1;
    tick();
    bus.s_hdr_tvalid = 1'b0;
    collect(fw, -1, 0);
    chk("post_abort_w0", 64'(fw[0]), 64'h0000_0000_A500_0000);
    chk("post_abort_w1", 64'(fw[1]), 64'h0000_0000_BBBB_CCCC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
